// File: rtl/outram_pkg.sv
// Shared state encoding and default widths for the output RAM sequencer.
package outram_pkg;

  localparam int unsigned OUTRAM_WIDTH     = 32;
  localparam int unsigned OUTRAM_ADDR_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } outram_state_e;

endpackage : outram_pkg

// File: rtl/output_ram_seq.sv
// Output RAM sequencer: collects a frame of result words into the external RAM,
// then drains it as a stream with TLAST. Optional stall counter: OUTRAM_STALL_CNT_EN.
module output_ram_seq
  import outram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = OUTRAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS = OUTRAM_ADDR_BITS,
  parameter int unsigned NUM_WORDS     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     res_valid,
  input  logic [RAM_WIDTH-1:0]     res_data,
  output logic                     res_ready,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_waddr,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  output logic [RAM_ADDR_BITS-1:0] ram_raddr,
  input  logic [RAM_WIDTH-1:0]     ram_rdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [RAM_WIDTH-1:0]     m_tdata,
  output logic                     m_tlast,
  output logic                     busy,
  output logic                     done
`ifdef OUTRAM_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned        CNT_W = RAM_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(NUM_WORDS - 1);

  outram_state_e    state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;

  // Sequencer: state plus the registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      res_ready <= 1'b0;
      m_tvalid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_COLLECT;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            res_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (res_valid) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == LAST) begin
              state     <= ST_DRAIN;
              res_ready <= 1'b0;
              m_tvalid  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // rd_cnt only moves on a handshake, so a stalled beat stays put.
          if (m_tready) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt == LAST) begin
              state    <= ST_DONE;
              m_tvalid <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          res_ready <= 1'b0;
          m_tvalid  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // RAM port and stream wiring; read data is asynchronous from the RAM.
  assign ram_we    = res_valid & res_ready;
  assign ram_wdata = res_data;
  assign ram_waddr = wr_cnt[RAM_ADDR_BITS-1:0];
  assign ram_raddr = rd_cnt[RAM_ADDR_BITS-1:0];
  assign m_tdata   = ram_rdata;
  assign m_tlast   = m_tvalid & (rd_cnt == LAST);

`ifdef OUTRAM_STALL_CNT_EN
  // Back-pressure cycles seen while draining; saturating, kept after the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= '0;
    end else if (m_tvalid && !m_tready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule : output_ram_seq

// File: tb/tb_output_ram_seq.sv
// Self-checking bench for output_ram_seq with a behavioural RAM and frame model.
module tb_output_ram_seq;

  logic        clk;
  logic        reset;

  logic        start, res_valid, m_tready;
  logic [31:0] res_data;
  logic        res_ready, ram_we, m_tvalid, m_tlast, busy, done;
  logic [1:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata, m_tdata;

  logic        start_1, res_valid_1, m_tready_1;
  logic [31:0] res_data_1;
  logic        res_ready_1, ram_we_1, m_tvalid_1, m_tlast_1, busy_1, done_1;
  logic [1:0]  ram_waddr_1, ram_raddr_1;
  logic [31:0] ram_wdata_1, ram_rdata_1, m_tdata_1;

`ifdef OUTRAM_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt_1;
`endif

  logic [31:0] mem0 [4];
  logic [31:0] mem1 [4];
  logic [31:0] fw   [4];

  int errors = 0;
  int checks = 0;

  output_ram_seq #(.RAM_WIDTH(32), .RAM_ADDR_BITS(2), .NUM_WORDS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .busy(busy), .done(done)
`ifdef OUTRAM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  output_ram_seq #(.RAM_WIDTH(32), .RAM_ADDR_BITS(2), .NUM_WORDS(1)) u_dut_1 (
    .clk(clk), .reset(reset), .start(start_1), .res_valid(res_valid_1), .res_data(res_data_1),
    .res_ready(res_ready_1), .ram_we(ram_we_1), .ram_waddr(ram_waddr_1), .ram_wdata(ram_wdata_1),
    .ram_raddr(ram_raddr_1), .ram_rdata(ram_rdata_1), .m_tvalid(m_tvalid_1), .m_tready(m_tready_1),
    .m_tdata(m_tdata_1), .m_tlast(m_tlast_1), .busy(busy_1), .done(done_1)
`ifdef OUTRAM_STALL_CNT_EN
    , .stall_cnt(stall_cnt_1)
`endif
  );

  // Behavioural 4-entry RAMs: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (ram_we)   mem0[ram_waddr]   <= ram_wdata;
    if (ram_we_1) mem1[ram_waddr_1] <= ram_wdata_1;
  end
  assign ram_rdata   = mem0[ram_raddr];
  assign ram_rdata_1 = mem1[ram_raddr_1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame on the 4-word DUT. The model: fw[] is written in order at
  // addresses 0..3 and streamed back in order, TLAST only on the last word.
  task automatic run_frame(input int gap_mode, input int stall_idx, input int stall_len,
                           input bit rand_ready, input bit spam);
    int idx, beat, cyc, stalls;
    start = 1'b1; res_valid = 1'b0; m_tready = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_res_ready", 32'(res_ready), 0);
    tick();
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 64) begin
      case (gap_mode)
        0:       res_valid = 1'b1;
        1:       res_valid = (cyc % 2) == 0;
        default: res_valid = 1'($urandom_range(0, 1));
      endcase
      res_data = fw[idx];
      start    = spam && (cyc == 1);
      #1;
      chk("collect_res_ready", 32'(res_ready), 1);
      chk("collect_we", 32'(ram_we), 32'(res_valid));
      chk("collect_tvalid", 32'(m_tvalid), 0);
      if (res_valid) begin
        chk("collect_waddr", 32'(ram_waddr), 32'(idx));
        chk("collect_wdata", ram_wdata, fw[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    chk("collect_count", 32'(idx), 4);
    beat = 0; stalls = 0; cyc = 0;
    while (beat < 4 && cyc < 64) begin
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      else            m_tready = !(beat == stall_idx && stalls < stall_len);
      start     = spam;
      res_valid = spam;
      #1;
      chk("drain_tvalid", 32'(m_tvalid), 1);
      chk("drain_tdata", m_tdata, fw[beat]);
      chk("drain_tlast", 32'(m_tlast), 32'(beat == 3));
      chk("drain_no_we", 32'(ram_we), 0);
      chk("drain_res_ready", 32'(res_ready), 0);
      chk("drain_done", 32'(done), 0);
      if (m_tready) beat++;
      else          stalls++;
      tick();
      cyc++;
    end
    chk("drain_count", 32'(beat), 4);
    start = spam; res_valid = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_tvalid", 32'(m_tvalid), 0);
    tick();
    start = 1'b0;
    #1;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_res_ready", 32'(res_ready), 0);
`ifdef OUTRAM_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
    tick();
    #1;
    chk("idle_after_frame", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; res_valid = 1'b0; res_data = '0; m_tready = 1'b0;
    start_1 = 1'b0; res_valid_1 = 1'b0; res_data_1 = '0; m_tready_1 = 1'b0;
    tick();
    tick();
    chk("rst_res_ready", 32'(res_ready), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_waddr", 32'(ram_waddr), 0);
    chk("rst_raddr", 32'(ram_raddr), 0);
`ifdef OUTRAM_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    reset = 1'b0;
    tick();

    // Stray valid in IDLE without start.
    res_valid = 1'b1; res_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stray_we", 32'(ram_we), 0);
      chk("stray_res_ready", 32'(res_ready), 0);
      tick();
    end
    res_valid = 1'b0;

    // Basic back-to-back frame.
    fw[0] = 32'h11; fw[1] = 32'h22; fw[2] = 32'h33; fw[3] = 32'h44;
    run_frame(0, -1, 0, 1'b0, 1'b0);

    // Three stall cycles on the second word.
    run_frame(0, 1, 3, 1'b0, 1'b0);

    // Gappy input with start and valid pulsed outside their windows.
    fw[0] = 32'hA5A5_0001; fw[1] = 32'h5A5A_0002; fw[2] = 32'h0F0F_0003; fw[3] = 32'hF0F0_0004;
    run_frame(1, -1, 0, 1'b0, 1'b1);

    // Mid-frame reset after the second accept.
    start = 1'b1;
    tick();
    start = 1'b0; res_valid = 1'b1; res_data = 32'h1234_5678;
    tick();
    res_data = 32'h8765_4321;
    tick();
    res_valid = 1'b0; reset = 1'b1;
    tick();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_res_ready", 32'(res_ready), 0);
    chk("abort_tvalid", 32'(m_tvalid), 0);
    chk("abort_waddr", 32'(ram_waddr), 0);
    chk("abort_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    fw[0] = 32'hCAFE_0000; fw[1] = 32'hCAFE_0001; fw[2] = 32'hCAFE_0002; fw[3] = 32'hCAFE_0003;
    run_frame(0, -1, 0, 1'b0, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) fw[k] = $urandom;
      run_frame(2, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    // Single-word frame on the NUM_WORDS=1 instance.
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0; res_valid_1 = 1'b1; res_data_1 = 32'hFFFF_FFFB;
    #1;
    chk("sw_res_ready", 32'(res_ready_1), 1);
    chk("sw_we", 32'(ram_we_1), 1);
    chk("sw_waddr", 32'(ram_waddr_1), 0);
    tick();
    res_valid_1 = 1'b0; m_tready_1 = 1'b1;
    #1;
    chk("sw_tvalid", 32'(m_tvalid_1), 1);
    chk("sw_tdata", m_tdata_1, 32'hFFFF_FFFB);
    chk("sw_tlast", 32'(m_tlast_1), 1);
    tick();
    #1;
    chk("sw_done", 32'(done_1), 1);
    chk("sw_tvalid_off", 32'(m_tvalid_1), 0);
    tick();
    #1;
    chk("sw_idle", 32'(busy_1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_output_ram_seq

// File: doc/output_ram_seq.md
Name: output_ram_seq

Overview:
- Sequencer for the 4-entry distributed output RAM at the coprocessor back end.
- Collects a frame of NUM_WORDS result words from the compute datapath over a valid/ready handshake and writes them into the RAM at addresses 0..NUM_WORDS-1.
- Then drains the frame to an AXI-Stream-style master port with TLAST on the final word.
- Storage is not inside this block: it drives the RAM's write/read ports and consumes its asynchronous read data.

Parameters:
- RAM_WIDTH, 32, data word width; matches the RAM.
- RAM_ADDR_BITS, 2, RAM address width.
- NUM_WORDS, 4, words per frame; legal range 1..2**RAM_ADDR_BITS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- res_valid  input  1  datapath result valid.
- res_data  input  RAM_WIDTH  signed result word.
- res_ready  output  1  block accepts result this cycle.
- ram_we  output  1  RAM write_enable.
- ram_waddr  output  RAM_ADDR_BITS  RAM write_address.
- ram_wdata  output  RAM_WIDTH  RAM_in.
- ram_raddr  output  RAM_ADDR_BITS  RAM read_addr.
- ram_rdata  input  RAM_WIDTH  RAM_out (combinational read).
- m_tvalid  output  1  stream data valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  RAM_WIDTH  stream data.
- m_tlast  output  1  last word of frame.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset (synchronous, active-high):
  - State goes to IDLE; wr_cnt and rd_cnt go to 0.
  - All outputs are 0: res_ready, ram_we, m_tvalid, m_tlast, busy, done, ram_waddr, ram_raddr.
  - RAM contents are not cleared.
  - Reset mid-frame aborts the frame; no further writes, no TLAST.
- Counters: wr_cnt and rd_cnt, each RAM_ADDR_BITS+1 bits.
  - ram_waddr = wr_cnt[RAM_ADDR_BITS-1:0].
  - ram_raddr = rd_cnt[RAM_ADDR_BITS-1:0].
- IDLE:
  - res_ready=0, m_tvalid=0.
  - start=1 -> COLLECT next cycle; wr_cnt=0, rd_cnt=0.
- COLLECT:
  - res_ready=1.
  - ram_we = res_valid & res_ready, combinationally; ram_wdata = res_data.
  - On each accept, wr_cnt increments.
  - Accept when wr_cnt==NUM_WORDS-1 -> DRAIN next cycle.
  - No wrap: exactly NUM_WORDS writes per frame.
- DRAIN:
  - m_tvalid=1.
  - m_tdata = ram_rdata (combinational from RAM at ram_raddr).
  - m_tlast = (rd_cnt==NUM_WORDS-1).
  - Handshake m_tvalid&m_tready increments rd_cnt.
  - While stalled, rd_cnt and therefore m_tdata are stable (AXI-S compliant); no RAM writes occur in DRAIN.
  - Handshake on the TLAST word -> DONE.
  - First m_tvalid appears 1 cycle after the final result accept.
- DONE:
  - done=1 for exactly one cycle, then IDLE; busy=1 during DONE.
  - A start asserted during DONE is ignored.
- start is ignored in every state except IDLE.
- res_valid outside COLLECT is ignored (res_ready=0).
- NUM_WORDS=1: COLLECT takes one write; DRAIN emits one word with m_tlast=1.
- Minimum frame time: 1 (IDLE->COLLECT) + NUM_WORDS + NUM_WORDS + 1 (DONE) cycles with no stalls.

Optional Feature:
- Macro OUTRAM_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts cycles in DRAIN with m_tvalid=1 and m_tready=0.
  - Cleared on reset and on IDLE->COLLECT; saturates at 16'hFFFF; holds its value after the frame.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `outram_pkg`:
  - State encoding typedef: IDLE=0, COLLECT=1, DRAIN=2, DONE=3.
  - Default width constants: OUTRAM_WIDTH=32, OUTRAM_ADDR_BITS=2.
- No sub-module inside the block. The existing 4-entry distributed RAM module is instantiated alongside it at the next level up, wired port-to-port.

Test Plan:
- Basic frame: reset, start; results 0x11, 0x22, 0x33, 0x44 back-to-back; m_tready=1 -> four ram_we pulses at addresses 0..3; stream 0x11..0x44 with m_tlast only on 0x44; done pulses 1 cycle after; busy falls with it.
- Stall: same frame, m_tready low for 3 cycles while the 2nd word is presented -> m_tdata holds 0x22 with m_tvalid high; no duplicate or lost words; with OUTRAM_STALL_CNT_EN defined, stall_cnt=3.
- Gappy input and ignored start: res_valid asserted every other cycle; start pulsed during COLLECT and DRAIN -> exactly 4 writes; start has no effect; exactly one frame output.
- Mid-frame reset: assert reset after the 2nd result accept -> next cycle busy=0, res_ready=0, m_tvalid=0; a new start runs a clean frame from address 0.
- Single-word frame: NUM_WORDS=1, result -5 (0xFFFFFFFB) -> a single stream beat 0xFFFFFFFB with m_tlast=1, then done.
- Stray valid: res_valid=1 in IDLE with no start for 10 cycles -> ram_we stays 0 and res_ready stays 0.
